// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display.
//   HEX_FONT  : 16-entry nibble -> active-low segment table, bit6=a .. bit0=g
//   SEG_OFF   : all segments dark (active-low)
//   AN_OFF/ON : anode drive levels (common-anode, active-low select)
//   DP_OFF    : decimal point dark
//   cnt_width : width of a counter covering 0..n-1 (never less than 1)
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic       AN_OFF  = 1'b1;
  localparam logic       AN_ON   = 1'b0;
  localparam logic       DP_OFF  = 1'b1;

  // Standard hex glyphs, lowercase b and d so they are distinguishable from 8 and 0.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h01,  // 0
    7'h4F,  // 1
    7'h12,  // 2
    7'h06,  // 3
    7'h4C,  // 4
    7'h24,  // 5
    7'h20,  // 6
    7'h0F,  // 7
    7'h00,  // 8
    7'h04,  // 9
    7'h08,  // A
    7'h60,  // b
    7'h31,  // C
    7'h42,  // d
    7'h30,  // E
    7'h38   // F
  };

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
//   nibble_i : 4-bit hex digit
//   seg_o    : segments, active-low, bit6=a .. bit0=g
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/display_7seg_scan.sv
// Multiplexed common-anode 7-segment scanner with per-digit decimal point,
// blink and blank masks, optional leading-zero suppression, an all-off guard
// interval at the start of every digit dwell, and double-buffered loads that
// only take effect at frame boundaries.
//   clk, rst   : clock, synchronous active-high reset
//   value_in   : packed hex nibbles, digit 0 = bits [3:0] (rightmost)
//   dp_in      : decimal point enable per digit
//   blink_in   : blink enable per digit
//   blank_in   : force digit dark
//   load       : one-cycle strobe capturing value/dp/blink/blank
//   an_out     : digit select, active-low
//   seg_out    : segments, active-low, bit6=a .. bit0=g
//   dp_out     : decimal point, active-low
//   frame_done : high during the last cycle of the last digit's dwell; a load
//                seen in that cycle lands directly in the next frame
module display_7seg_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DWELL_TICKS = 50000,
  parameter int GUARD_TICKS = 500,
  parameter int BLINK_HALF  = 25000000,
  parameter int LZ_BLANK    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic                    frame_done
);

  localparam int IDX_W = cnt_width(NUM_DIGITS);
  localparam int DWL_W = cnt_width(DWELL_TICKS);
  localparam int BLK_W = cnt_width(BLINK_HALF);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DWL_W-1:0] DWL_LAST  = DWL_W'(DWELL_TICKS - 1);
  localparam logic [DWL_W-1:0] GUARD_END = DWL_W'(GUARD_TICKS);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_HALF - 1);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] val;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink;
    logic [NUM_DIGITS-1:0]   blank;
  } disp_buf_t;

  // Scan and blink state
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DWL_W-1:0] dwell_q, dwell_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;

  // Double buffer
  disp_buf_t act_q, act_d;
  disp_buf_t stg_q, stg_d;
  disp_buf_t in_buf;
  logic      pending_q, pending_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_done_q, frame_done_d;

  logic dwell_wrap;
  logic frame_end;

  // Current digit view
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_blank;
  logic                  cur_lz;
  logic                  cur_dark;
  logic [6:0]            font_seg;
  logic [NUM_DIGITS-1:0] lz_sup;
  logic                  zero_above;

  // ---------------------------------------------------------------------------
  // Scan and blink counters
  // ---------------------------------------------------------------------------
  assign dwell_wrap = (dwell_q == DWL_LAST);
  // frame_end marks the clock edge on which the index wraps back to digit 0.
  assign frame_end  = dwell_wrap && (idx_q == IDX_LAST);

  always_comb begin
    dwell_d      = dwell_q;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    frame_done_d = 1'b0;

    if (dwell_wrap) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      dwell_d = dwell_q + 1'b1;
    end

    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    // Registered so it is high exactly while the wrapping cycle is current.
    frame_done_d = (idx_d == IDX_LAST) && (dwell_d == DWL_LAST);
  end

  // ---------------------------------------------------------------------------
  // Double buffer: loads go to staging and are promoted only at frame_end, so
  // the active buffer is constant for a whole frame. A load on the frame_end
  // edge itself bypasses staging.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_buf       = '0;
    in_buf.val   = value_in;
    in_buf.dp    = dp_in;
    in_buf.blink = blink_in;
    in_buf.blank = blank_in;
  end

  always_comb begin
    act_d     = act_q;
    stg_d     = stg_q;
    pending_d = pending_q;

    if (load) begin
      if (frame_end) begin
        act_d     = in_buf;
        pending_d = 1'b0;
      end else begin
        stg_d     = in_buf;
        pending_d = 1'b1;
      end
    end else if (frame_end && pending_q) begin
      act_d     = stg_q;
      pending_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero suppression: digit d>0 goes dark when it and every digit to
  // its left hold zero. Digit 0 is never suppressed.
  // ---------------------------------------------------------------------------
  always_comb begin
    lz_sup     = '0;
    zero_above = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      zero_above = zero_above && (act_q.val[4*d +: 4] == 4'h0);
      lz_sup[d]  = zero_above && (LZ_BLANK != 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Current digit selection and output pattern
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) begin
        cur_nib   = act_q.val[4*d +: 4];
        cur_dp    = act_q.dp[d];
        cur_blink = act_q.blink[d];
        cur_blank = act_q.blank[d];
        cur_lz    = lz_sup[d];
      end
    end
  end

  assign cur_dark = cur_blank || (cur_blink && !blink_on_q) || cur_lz;

  hex_to_7seg u_font (
    .nibble_i (cur_nib),
    .seg_o    (font_seg)
  );

  always_comb begin
    an_d  = {NUM_DIGITS{AN_OFF}};
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    // During the guard interval everything stays off so the previous digit's
    // pattern cannot ghost onto the newly selected anode.
    if (dwell_q >= GUARD_END) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (idx_q == IDX_W'(d)) begin
          an_d[d] = AN_ON;
        end
      end
      if (!cur_dark) begin
        seg_d = font_seg;
        dp_d  = ~cur_dp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      dwell_q      <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      act_q        <= '0;
      stg_q        <= '0;
      pending_q    <= 1'b0;
      an_q         <= {NUM_DIGITS{AN_OFF}};
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      dwell_q      <= dwell_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      act_q        <= act_d;
      stg_q        <= stg_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an_out     = an_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_7seg_scan.sv
// Directed bench for display_7seg_scan. Two instances share all inputs: one
// without and one with leading-zero suppression. Each frame is checked cycle
// by cycle against hand-computed segment patterns.
module tb_display_7seg_scan;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int GT = 2;
  localparam int BH = 64;
  localparam int FRAME = N * DW;

  // Hand-computed glyphs (active-low, a..g)
  localparam logic [6:0] S0 = 7'h01, S1 = 7'h4F, S2 = 7'h12, S3 = 7'h06;
  localparam logic [6:0] S5 = 7'h24, S6 = 7'h20, S7 = 7'h0F, S8 = 7'h00;
  localparam logic [6:0] SA = 7'h08, SF = 7'h38, SX = 7'h7F;

  // ---------------------------------------------------------------------------
  // Clock / reset / stimulus signals
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   value_in = '0;
  logic [N-1:0]  dp_in = '0;
  logic [N-1:0]  blink_in = '0;
  logic [N-1:0]  blank_in = '0;
  logic          load = 1'b0;

  logic [N-1:0]  an_a, an_b;
  logic [6:0]    seg_a, seg_b;
  logic          dp_a, dp_b;
  logic          fd_a, fd_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  display_7seg_scan #(
    .NUM_DIGITS(N), .DWELL_TICKS(DW), .GUARD_TICKS(GT), .BLINK_HALF(BH), .LZ_BLANK(0)
  ) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .blink_in(blink_in),
    .blank_in(blank_in), .load(load), .an_out(an_a), .seg_out(seg_a), .dp_out(dp_a),
    .frame_done(fd_a)
  );

  display_7seg_scan #(
    .NUM_DIGITS(N), .DWELL_TICKS(DW), .GUARD_TICKS(GT), .BLINK_HALF(BH), .LZ_BLANK(1)
  ) dut_lz (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .blink_in(blink_in),
    .blank_in(blank_in), .load(load), .an_out(an_b), .seg_out(seg_b), .dp_out(dp_b),
    .frame_done(fd_b)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_pins(input string tag, input logic [N-1:0] an_e,
                            input logic [6:0] sa_e, input logic da_e,
                            input logic [6:0] sb_e, input logic db_e, input logic fd_e);
    check({tag, " an"},     an_a, an_e);
    check({tag, " seg"},    seg_a, sa_e);
    check({tag, " dp"},     dp_a, da_e);
    check({tag, " fd"},     fd_a, fd_e);
    check({tag, " lz_an"},  an_b, an_e);
    check({tag, " lz_seg"}, seg_b, sb_e);
    check({tag, " lz_dp"},  dp_b, db_e);
    check({tag, " lz_fd"},  fd_b, fd_e);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds rst for three edges and checks the dark reset outputs after each.
  task automatic do_reset(input string tag);
    rst  = 1'b1;
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pins($sformatf("%s r%0d", tag, i), {N{1'b1}}, SX, 1'b1, SX, 1'b1, 1'b0);
    end
    rst = 1'b0;
  endtask

  // Runs one full frame from a frame-start state. sa/da are the expected
  // segments/dp_out per digit for the plain instance, sb/db for the
  // suppressing one, packed {d3,d2,d1,d0}. Optional loads at cycles l1_j/l2_j.
  task automatic expect_frame(input string tag,
                              input logic [27:0] sa, input logic [3:0] da,
                              input logic [27:0] sb, input logic [3:0] db,
                              input int l1_j, input logic [15:0] l1_v,
                              input int l2_j, input logic [15:0] l2_v);
    int d;
    int w;
    logic [N-1:0] an_e;
    logic [6:0]   sa_e, sb_e;
    logic         da_e, db_e;
    for (int j = 0; j < FRAME; j++) begin
      if (j == l1_j) begin value_in = l1_v; load = 1'b1; end
      if (j == l2_j) begin value_in = l2_v; load = 1'b1; end
      tick();
      load = 1'b0;
      d = j / DW;
      w = j % DW;
      if (w < GT) begin
        an_e = {N{1'b1}};
        sa_e = SX; sb_e = SX;
        da_e = 1'b1; db_e = 1'b1;
      end else begin
        an_e = ~(4'b0001 << d);
        sa_e = sa[7*d +: 7];
        sb_e = sb[7*d +: 7];
        da_e = da[d];
        db_e = db[d];
      end
      check_pins($sformatf("%s d%0d c%0d", tag, d, w), an_e, sa_e, da_e, sb_e, db_e,
                 (j == FRAME - 2));
    end
  endtask

  function automatic logic [27:0] segs4(input logic [6:0] s3, input logic [6:0] s2,
                                        input logic [6:0] s1, input logic [6:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [27:0] zero_a, zero_b;
    zero_a = segs4(S0, S0, S0, S0);
    zero_b = segs4(SX, SX, SX, S0);

    do_reset("rst0");

    // Load 12AF in frame 0; it must only appear from frame 1.
    expect_frame("t1f0", zero_a, 4'hF, zero_b, 4'hF, 0, 16'h12AF, -1, 16'h0);
    expect_frame("t1f1", segs4(S1, S2, SA, SF), 4'hF, segs4(S1, S2, SA, SF), 4'hF,
                 -1, 16'h0, -1, 16'h0);

    // Mid-scan reset: active buffer returns to zero.
    repeat (13) tick();
    do_reset("t2rst");
    dp_in    = 4'b0101;
    blank_in = 4'b1000;
    expect_frame("t2f0", zero_a, 4'hF, zero_b, 4'hF, 5, 16'h9876, -1, 16'h0);

    // dp on digits 0 and 2, digit 3 blanked.
    dp_in    = 4'b0010;
    blank_in = 4'b0000;
    expect_frame("mskf1", segs4(SX, S8, S7, S6), 4'b1010, segs4(SX, S8, S7, S6), 4'b1010,
                 3, 16'h0005, -1, 16'h0);

    // Leading-zero suppression, dp of a suppressed digit stays dark.
    expect_frame("lzf2", segs4(S0, S0, S0, S5), 4'b1101, segs4(SX, SX, SX, S5), 4'b1111,
                 7, 16'h0000, -1, 16'h0);
    dp_in = 4'b0000;
    expect_frame("lzf3", segs4(S0, S0, S0, S0), 4'b1101, segs4(SX, SX, SX, S0), 4'b1111,
                 9, 16'h0500, -1, 16'h0);
    expect_frame("lzf4", segs4(S0, S5, S0, S0), 4'hF, segs4(SX, S5, S0, S0), 4'hF,
                 -1, 16'h0, -1, 16'h0);

    // Blink on digit 1: phase on for frames 0-1, off for 2-3, on for 4-5.
    do_reset("rst1");
    blink_in = 4'b0010;
    expect_frame("blf0", zero_a, 4'hF, zero_b, 4'hF, 0, 16'h3333, -1, 16'h0);
    expect_frame("blf1", segs4(S3, S3, S3, S3), 4'hF, segs4(S3, S3, S3, S3), 4'hF,
                 -1, 16'h0, -1, 16'h0);
    expect_frame("blf2", segs4(S3, S3, SX, S3), 4'hF, segs4(S3, S3, SX, S3), 4'hF,
                 -1, 16'h0, -1, 16'h0);
    expect_frame("blf3", segs4(S3, S3, SX, S3), 4'hF, segs4(S3, S3, SX, S3), 4'hF,
                 -1, 16'h0, -1, 16'h0);
    expect_frame("blf4", segs4(S3, S3, S3, S3), 4'hF, segs4(S3, S3, S3, S3), 4'hF,
                 -1, 16'h0, -1, 16'h0);

    // Two loads in one frame: frame unchanged, last load wins next frame.
    blink_in = 4'b0000;
    expect_frame("dbf5", segs4(S3, S3, S3, S3), 4'hF, segs4(S3, S3, S3, S3), 4'hF,
                 10, 16'h1111, 20, 16'h2222);
    expect_frame("dbf6", segs4(S2, S2, S2, S2), 4'hF, segs4(S2, S2, S2, S2), 4'hF,
                 -1, 16'h0, -1, 16'h0);

    // Staged 5555, then 7777 in the frame_done cycle: 7777 shows next frame
    // and the stale staged value must never be promoted.
    expect_frame("fbf7", segs4(S2, S2, S2, S2), 4'hF, segs4(S2, S2, S2, S2), 4'hF,
                 3, 16'h5555, FRAME - 1, 16'h7777);
    expect_frame("fbf8", segs4(S7, S7, S7, S7), 4'hF, segs4(S7, S7, S7, S7), 4'hF,
                 -1, 16'h0, -1, 16'h0);
    expect_frame("fbf9", segs4(S7, S7, S7, S7), 4'hF, segs4(S7, S7, S7, S7), 4'hF,
                 -1, 16'h0, -1, 16'h0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
